// File: rtl/aria_pkg.sv
`default_nettype none
// ============================================================================
// Module   : aria_pkg
// Purpose  : Shared definitions for the ARIA host write buffer.
//            - Block width and pad byte constants
//            - One-hot FSM state encoding
//            - Byte masker helper for the final partial word
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package aria_pkg;

  localparam int         ARIA_BLK_W    = 128;
  localparam logic [7:0] ARIA_PAD_BYTE = 8'h80;

  typedef enum logic [3:0] {
    ST_IDLE = 4'b0001,
    ST_FILL = 4'b0010,
    ST_PAD  = 4'b0100,
    ST_OUT  = 4'b1000
  } wb_state_e;

  // Keep the first nb bytes (byte 0 in [31:24]) and zero the rest.
  // With pad80 set, the byte right after the last kept byte becomes the
  // pad marker; nb==4 leaves no room, so the marker goes into a pad word.
  function automatic logic [31:0] aria_mask_word(input logic [31:0] w,
                                                 input logic [2:0]  nb,
                                                 input logic        pad80);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 4; i++) begin
      if (i < int'(nb)) begin
        r[31-8*i -: 8] = w[31-8*i -: 8];
      end else if (pad80 && (i == int'(nb))) begin
        r[31-8*i -: 8] = ARIA_PAD_BYTE;
      end
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/aria_wr_fifo.sv
`default_nettype none
// ============================================================================
// Module   : aria_wr_fifo
// Purpose  : Synchronous word FIFO, 2^FIFO_AW entries of DATA_W bits.
//            Read data is presented combinationally from the read pointer.
// Ports    : clk, rst_n      clock, async active-low reset
//            clr_i           synchronous flush (pointers and count to 0)
//            push_i, data_i  write request and data (ignored when full)
//            pop_i, data_o   read request and head-of-queue data
//            count_o         registered occupancy
//            full_o          occupancy == depth
// Revision : 1.0 - initial release
// ============================================================================
module aria_wr_fifo #(
  parameter int FIFO_AW = 4,
  parameter int DATA_W  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr_i,
  input  logic              push_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              pop_i,
  output logic [DATA_W-1:0] data_o,
  output logic [FIFO_AW:0]  count_o,
  output logic              full_o
);

  localparam int             DEPTH    = 1 << FIFO_AW;
  localparam logic [FIFO_AW:0] FULL_CNT = DEPTH[FIFO_AW:0];

  logic [DATA_W-1:0]  mem_q [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr_q;
  logic [FIFO_AW-1:0] rd_ptr_q;
  logic [FIFO_AW:0]   count_q;
  logic               do_push;
  logic               do_pop;

  assign full_o  = (count_q == FULL_CNT);
  assign count_o = count_q;
  assign data_o  = mem_q[rd_ptr_q];

  // A push while full is dropped even if a pop frees a slot this cycle.
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & (count_q != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (clr_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule
`default_nettype wire

// File: rtl/aria_wr_buf.sv
`default_nettype none
// ============================================================================
// Module   : aria_wr_buf
// Purpose  : Host-side write buffer for the ARIA core. Buffers 32-bit host
//            words, packs them MSW-first into 128-bit blocks against a byte
//            count, masks/pads the final block and offers each block to the
//            core over a vld/rdy handshake.
// Config   : ARIA_WB_PAD80_EN - when defined, ISO/IEC 7816-4 padding
//            (0x80 after the last valid byte, zeros after). Undefined: zero
//            masking/padding only.
// Ports    : clk, rst_n            clock, async active-low reset
//            clr_core              sync clear of FSM, counters and FIFO
//            wb_en, cmd_extend     start command, byte length
//            wr_en, wr_d           host word write
//            wr_full, wr_ovf       FIFO full, sticky dropped-write flag
//            wb_do, wb_d_vld       block data and valid to core
//            wb_d_rdy              core accepts block
//            wb_done               idle with no bytes outstanding
// Revision : 1.0 - initial release
// ============================================================================
module aria_wr_buf
  import aria_pkg::*;
#(
  parameter int FIFO_AW = 4,
  parameter int CNT_W   = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr_core,
  input  logic                  wb_en,
  input  logic [CNT_W-1:0]      cmd_extend,
  input  logic                  wr_en,
  input  logic [31:0]           wr_d,
  output logic                  wr_full,
  output logic                  wr_ovf,
  output logic [ARIA_BLK_W-1:0] wb_do,
  output logic                  wb_d_vld,
  input  logic                  wb_d_rdy,
  output logic                  wb_done
);

`ifdef ARIA_WB_PAD80_EN
  localparam bit PAD80_EN = 1'b1;
`else
  localparam bit PAD80_EN = 1'b0;
`endif

  wb_state_e             state_q, state_d;
  logic [CNT_W-1:0]      cntr_q, cntr_d;
  logic [ARIA_BLK_W-1:0] buf_q, buf_d;
  logic [1:0]            loop_q, loop_d;
  logic                  ovf_q, ovf_d;
  // Word-aligned message end: the first pad word carries the 0x80 marker.
  logic                  pad80_q, pad80_d;

  logic [31:0]           fifo_dout;
  logic [FIFO_AW:0]      fifo_count;
  logic                  fifo_full;
  logic                  fifo_pop;
  logic                  fifo_clr;

  logic [2:0]            nb;
  logic [CNT_W-1:0]      cntr_nxt;
  logic [31:0]           word_m;

  assign fifo_clr = clr_core | wb_en;

  aria_wr_fifo #(
    .FIFO_AW (FIFO_AW),
    .DATA_W  (32)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr_i   (fifo_clr),
    .push_i  (wr_en),
    .data_i  (wr_d),
    .pop_i   (fifo_pop),
    .data_o  (fifo_dout),
    .count_o (fifo_count),
    .full_o  (fifo_full)
  );

  always_comb begin
    state_d  = state_q;
    cntr_d   = cntr_q;
    buf_d    = buf_q;
    loop_d   = loop_q;
    pad80_d  = pad80_q;
    fifo_pop = 1'b0;
    ovf_d    = ovf_q | (wr_en & fifo_full);

    // Valid bytes in the head word: all four unless the count runs out.
    nb       = (cntr_q >= CNT_W'(4)) ? 3'd4 : cntr_q[2:0];
    cntr_nxt = (cntr_q < CNT_W'(5)) ? '0 : (cntr_q - CNT_W'(4));
    word_m   = aria_mask_word(fifo_dout, nb, PAD80_EN);

    case (state_q)
      ST_IDLE: begin
        if (cntr_q != '0) state_d = ST_FILL;
      end
      ST_FILL: begin
        if (fifo_count != '0) begin
          fifo_pop = 1'b1;
          buf_d    = {buf_q[ARIA_BLK_W-33:0], word_m};
          loop_d   = loop_q + 2'd1;
          cntr_d   = cntr_nxt;
          if (loop_q == 2'd3) begin
            state_d = ST_OUT;
          end else if (cntr_nxt == '0) begin
            state_d = ST_PAD;
            pad80_d = PAD80_EN && (nb == 3'd4);
          end
        end
      end
      ST_PAD: begin
        buf_d   = {buf_q[ARIA_BLK_W-33:0],
                   (pad80_q ? {ARIA_PAD_BYTE, 24'h0} : 32'h0)};
        pad80_d = 1'b0;
        loop_d  = loop_q + 2'd1;
        if (loop_q == 2'd3) state_d = ST_OUT;
      end
      ST_OUT: begin
        if (wb_d_rdy) begin
          loop_d  = 2'd0;
          buf_d   = '0;
          state_d = (cntr_q != '0) ? ST_FILL : ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (clr_core) begin
      state_d  = ST_IDLE;
      cntr_d   = '0;
      buf_d    = '0;
      loop_d   = 2'd0;
      ovf_d    = 1'b0;
      pad80_d  = 1'b0;
      fifo_pop = 1'b0;
    end else if (wb_en) begin
      state_d  = ST_IDLE;
      cntr_d   = cmd_extend;
      buf_d    = '0;
      loop_d   = 2'd0;
      ovf_d    = 1'b0;
      pad80_d  = 1'b0;
      fifo_pop = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cntr_q  <= '0;
      buf_q   <= '0;
      loop_q  <= 2'd0;
      ovf_q   <= 1'b0;
      pad80_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cntr_q  <= cntr_d;
      buf_q   <= buf_d;
      loop_q  <= loop_d;
      ovf_q   <= ovf_d;
      pad80_q <= pad80_d;
    end
  end

  assign wr_full  = fifo_full;
  assign wr_ovf   = ovf_q;
  assign wb_do    = buf_q;
  assign wb_d_vld = (state_q == ST_OUT);
  assign wb_done  = (state_q == ST_IDLE) && (cntr_q == '0);

endmodule
`default_nettype wire

// File: tb/tb_aria_wr_buf.sv
`default_nettype none
// ============================================================================
// Module   : tb_aria_wr_buf
// Purpose  : Self-checking bench for aria_wr_buf. Expected blocks come from a
//            byte-stream model: take the first len message bytes, append the
//            pad marker when ARIA_WB_PAD80_EN is defined and len is not a
//            multiple of 16, zero-fill to whole 16-byte blocks.
// Revision : 1.0 - initial release
// ============================================================================
module tb_aria_wr_buf;

`ifdef ARIA_WB_PAD80_EN
  localparam bit TB_PAD80 = 1'b1;
`else
  localparam bit TB_PAD80 = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         clr_core = 1'b0;
  logic         wb_en = 1'b0;
  logic [15:0]  cmd_extend = '0;
  logic         wr_en = 1'b0;
  logic [31:0]  wr_d = '0;
  logic         wb_d_rdy = 1'b0;
  logic         wr_full, wr_ovf, wb_d_vld, wb_done;
  logic [127:0] wb_do;

  int checks = 0;
  int failures = 0;

  logic [31:0]  msg_words[$];
  logic [127:0] exp_blocks[$];
  logic [127:0] got_blocks[$];

  always #5 clk = ~clk;

  aria_wr_buf #(.FIFO_AW(4), .CNT_W(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr_core   (clr_core),
    .wb_en      (wb_en),
    .cmd_extend (cmd_extend),
    .wr_en      (wr_en),
    .wr_d       (wr_d),
    .wr_full    (wr_full),
    .wr_ovf     (wr_ovf),
    .wb_do      (wb_do),
    .wb_d_vld   (wb_d_vld),
    .wb_d_rdy   (wb_d_rdy),
    .wb_done    (wb_done)
  );

  // Reference model: message bytes -> padded 128-bit blocks.
  function automatic void build_expected(input int len);
    int nblk;
    int i;
    logic [31:0]  w;
    logic [7:0]   b;
    logic [127:0] blk;
    exp_blocks.delete();
    nblk = (len + 15) / 16;
    for (int k = 0; k < nblk; k++) begin
      blk = '0;
      for (int j = 0; j < 16; j++) begin
        i = 16 * k + j;
        if (i < len) begin
          w = msg_words[i / 4];
          b = w[31 - 8 * (i % 4) -: 8];
        end else if (TB_PAD80 && (i == len)) begin
          b = 8'h80;
        end else begin
          b = 8'h00;
        end
        blk[127 - 8 * j -: 8] = b;
      end
      exp_blocks.push_back(blk);
    end
  endfunction

  task automatic start_cmd(input int len);
    @(negedge clk);
    cmd_extend = len[15:0];
    wb_en = 1'b1;
    @(negedge clk);
    wb_en = 1'b0;
  endtask

  // Runs one message with random write/ready timing; msg_words must hold
  // (len+3)/4 + extra words. Leaves the bench at a negedge.
  task automatic run_msg(input int len, input int extra, input int rdy_pct, input int wr_pct);
    int nw;
    int widx;
    int budget;
    bit fin;
    nw = (len + 3) / 4 + extra;
    build_expected(len);
    got_blocks.delete();
    start_cmd(len);
    widx = 0;
    budget = 0;
    fin = 1'b0;
    while (budget < 3000 && !fin) begin
      wr_en = (widx < nw) && !wr_full && (int'($urandom_range(99)) < wr_pct);
      if (wr_en) begin
        wr_d = msg_words[widx];
        widx++;
      end
      wb_d_rdy = (int'($urandom_range(99)) < rdy_pct);
      if (wb_d_vld && wb_d_rdy) begin
        checks++;
        if (got_blocks.size() >= exp_blocks.size()) begin
          failures++;
          $display("FAIL msg_len%0d_extra_block: got %h required none", len, wb_do);
        end else if (wb_do !== exp_blocks[got_blocks.size()]) begin
          failures++;
          $display("FAIL msg_len%0d_blk%0d: got %h required %h", len, got_blocks.size(), wb_do, exp_blocks[got_blocks.size()]);
        end
        got_blocks.push_back(wb_do);
      end
      if (got_blocks.size() == exp_blocks.size() && wb_done) fin = 1'b1;
      else begin
        @(negedge clk);
        budget++;
      end
    end
    wr_en = 1'b0;
    wb_d_rdy = 1'b0;
    checks++;
    if (!fin) begin
      failures++;
      $display("FAIL msg_len%0d_timeout: got %0d blocks required %0d with wb_done", len, got_blocks.size(), exp_blocks.size());
    end
    checks++;
    if (wr_ovf !== 1'b0) begin
      failures++;
      $display("FAIL msg_len%0d_ovf: got %b required 0", len, wr_ovf);
    end
  endtask

  task automatic wait_vld(output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 200 && !ok; n++) begin
      if (wb_d_vld) ok = 1'b1;
      else @(negedge clk);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if ({wr_full, wr_ovf, wb_d_vld, wb_done} !== 4'b0001 || wb_do !== '0) begin
      failures++;
      $display("FAIL reset_state: got full/ovf/vld/done=%b do=%h required 0001 do=0", {wr_full, wr_ovf, wb_d_vld, wb_done}, wb_do);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_full_block();
    msg_words = '{32'h00112233, 32'h44556677, 32'h8899AABB, 32'hCCDDEEFF};
    run_msg(16, 0, 100, 100);
    checks++;
    if (got_blocks.size() != 1 || got_blocks[0] !== 128'h00112233_44556677_8899AABB_CCDDEEFF) begin
      failures++;
      $display("FAIL full_block: got %0d blocks first %h required 1 block 00112233445566778899aabbccddeeff", got_blocks.size(), (got_blocks.size() > 0) ? got_blocks[0] : 128'h0);
    end
  endtask

  task automatic test_partial();
    logic [127:0] req;
    msg_words = '{32'h11223344, 32'h55667788};
    req = TB_PAD80 ? 128'h11223344_55800000_00000000_00000000 : 128'h11223344_55000000_00000000_00000000;
    run_msg(5, 0, 100, 100);
    checks++;
    if (got_blocks.size() != 1 || got_blocks[0] !== req) begin
      failures++;
      $display("FAIL partial_len5: got %0d blocks first %h required 1 block %h", got_blocks.size(), (got_blocks.size() > 0) ? got_blocks[0] : 128'h0, req);
    end
  endtask

  task automatic test_aligned8();
    logic [127:0] req;
    msg_words = '{32'hAAAAAAAA, 32'hBBBBBBBB};
    req = TB_PAD80 ? 128'hAAAAAAAA_BBBBBBBB_80000000_00000000 : 128'hAAAAAAAA_BBBBBBBB_00000000_00000000;
    run_msg(8, 0, 100, 100);
    checks++;
    if (got_blocks.size() != 1 || got_blocks[0] !== req) begin
      failures++;
      $display("FAIL aligned_len8: got %0d blocks first %h required 1 block %h", got_blocks.size(), (got_blocks.size() > 0) ? got_blocks[0] : 128'h0, req);
    end
  endtask

  task automatic test_back_pressure();
    bit ok;
    bit stable;
    int hs;
    logic [127:0] hold;
    msg_words.delete();
    for (int i = 0; i < 8; i++) msg_words.push_back($urandom);
    build_expected(32);
    start_cmd(32);
    wb_d_rdy = 1'b0;
    for (int i = 0; i < 8; i++) begin
      wr_en = 1'b1;
      wr_d = msg_words[i];
      @(negedge clk);
    end
    wr_en = 1'b0;
    wait_vld(ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL bp_first_vld: got vld=0 required 1 within budget");
    end
    hold = wb_do;
    stable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (!wb_d_vld || wb_do !== hold) stable = 1'b0;
    end
    checks++;
    if (!stable) begin
      failures++;
      $display("FAIL bp_hold: got vld=%b do=%h required vld=1 do=%h", wb_d_vld, wb_do, hold);
    end
    wb_d_rdy = 1'b1;
    hs = 0;
    for (int n = 0; n < 200; n++) begin
      if (wb_d_vld) begin
        checks++;
        if (hs >= 2 || wb_do !== exp_blocks[hs]) begin
          failures++;
          $display("FAIL bp_blk%0d: got %h required %h", hs, wb_do, (hs < 2) ? exp_blocks[hs] : 128'h0);
        end
        hs++;
      end
      if (hs >= 2 && wb_done) break;
      @(negedge clk);
    end
    wb_d_rdy = 1'b0;
    checks++;
    if (hs != 2 || !wb_done) begin
      failures++;
      $display("FAIL bp_handshakes: got %0d done=%b required 2 done=1", hs, wb_done);
    end
  endtask

  task automatic test_overflow();
    start_cmd(0);
    for (int i = 0; i < 16; i++) begin
      wr_en = 1'b1;
      wr_d = $urandom;
      @(negedge clk);
      if (i == 14) begin
        checks++;
        if (wr_full !== 1'b0) begin
          failures++;
          $display("FAIL ovf_15_words_full: got %b required 0", wr_full);
        end
      end
    end
    checks++;
    if (wr_full !== 1'b1 || wr_ovf !== 1'b0) begin
      failures++;
      $display("FAIL ovf_16_words: got full=%b ovf=%b required full=1 ovf=0", wr_full, wr_ovf);
    end
    wr_d = $urandom;
    @(negedge clk);
    wr_en = 1'b0;
    checks++;
    if (wr_full !== 1'b1 || wr_ovf !== 1'b1 || wb_done !== 1'b1 || wb_d_vld !== 1'b0) begin
      failures++;
      $display("FAIL ovf_17th_dropped: got full=%b ovf=%b done=%b vld=%b required 1 1 1 0", wr_full, wr_ovf, wb_done, wb_d_vld);
    end
    start_cmd(0);
    checks++;
    if (wr_ovf !== 1'b0 || wr_full !== 1'b0) begin
      failures++;
      $display("FAIL ovf_cleared_by_wb_en: got ovf=%b full=%b required 0 0", wr_ovf, wr_full);
    end
  endtask

  task automatic test_clr_in_out();
    bit ok;
    start_cmd(16);
    wb_d_rdy = 1'b0;
    for (int i = 0; i < 6; i++) begin
      wr_en = 1'b1;
      wr_d = $urandom;
      @(negedge clk);
    end
    wr_en = 1'b0;
    wait_vld(ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL clr_pre_vld: got vld=0 required 1 within budget");
    end
    clr_core = 1'b1;
    @(negedge clk);
    clr_core = 1'b0;
    checks++;
    if (wb_d_vld !== 1'b0 || wb_do !== '0 || wb_done !== 1'b1 || wr_full !== 1'b0) begin
      failures++;
      $display("FAIL clr_in_out: got vld=%b do=%h done=%b full=%b required 0 0 1 0", wb_d_vld, wb_do, wb_done, wr_full);
    end
    // Leftover words must be gone: a fresh one-word message sees only its own data.
    msg_words = '{$urandom};
    run_msg(4, 0, 100, 100);
  endtask

  task automatic test_async_reset();
    bit ok;
    start_cmd(16);
    for (int i = 0; i < 4; i++) begin
      wr_en = 1'b1;
      wr_d = $urandom;
      @(negedge clk);
    end
    wr_en = 1'b0;
    wait_vld(ok);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (!ok || wb_d_vld !== 1'b0 || wb_do !== '0 || wb_done !== 1'b1) begin
      failures++;
      $display("FAIL async_reset: got seen_vld=%b vld=%b do=%h done=%b required 1 0 0 1", ok, wb_d_vld, wb_do, wb_done);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_random();
    int lens[10];
    int len;
    int extra;
    lens = '{1, 3, 4, 12, 15, 16, 17, 48, 0, 0};
    for (int t = 0; t < 18; t++) begin
      len = (t < 8) ? lens[t] : int'($urandom_range(70, 1));
      extra = int'($urandom_range(2, 0));
      msg_words.delete();
      for (int i = 0; i < (len + 3) / 4 + extra; i++) msg_words.push_back($urandom);
      run_msg(len, extra, int'($urandom_range(100, 30)), int'($urandom_range(100, 30)));
    end
  endtask

  initial begin
    test_reset();
    test_full_block();
    test_partial();
    test_aligned8();
    test_back_pressure();
    test_overflow();
    test_clr_in_out();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
